stream_mux_nto1: RTL and testbench

Registered N-to-1 stream selector for the CGRA interconnect. It is the parametrised successor to the fixed 5:1 data mux. The select is held in a configuration register instead of a free-running input. Each input and the output carry valid/ready handshakes, and the output is registered with full throughput. It sits between the PE output ports and a PE operand input, so routing is programmed once per kernel while data streams through.

---
 rtl/cgra_pkg.sv | 27 ++
 rtl/mux_nto1.sv | 21 ++
 rtl/stream_mux_nto1.sv | 82 ++++++++
 tb/tb_stream_mux_nto1.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared constants and helpers for the CGRA interconnect blocks.
`ifndef CGRA_PKG_SV
`define CGRA_PKG_SV

// Channel i of a flattened bus of w-bit channels.
`define CGRA_CH(bus, i, w) bus[(i)*(w) +: (w)]

package cgra_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  function automatic int clog2(input int value);
    int result;
    int x;
    result = 0;
    x = value - 1;
    while (x > 0) begin
      result = result + 1;
      x = x >>> 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/mux_nto1.sv
// Combinational N-to-1 channel selector over a flattened bus; out-of-range select yields 0.
module mux_nto1
  import cgra_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = 5,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data
);

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) out_data = `CGRA_CH(in_data, i, WIDTH);
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 stream selector with configured select, valid/ready handshakes
// on every channel, a full-throughput output register and a saturating beat counter.
module stream_mux_nto1
  import cgra_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = 5,
  parameter int CNT_W = DEF_CNT_W,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_sel,
  output logic                  cfg_err,
  output logic [SEL_W-1:0]      cur_sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      xfer_cnt
);

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] mux_data;
  logic             can_take;
  logic             sel_valid;
  logic             acc;
  logic             cfg_ok;

  mux_nto1 #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (mux_data)
  );

  assign can_take = !out_valid || out_ready;
  assign cfg_ok   = {1'b0, cfg_sel} < (SEL_W+1)'(N_IN);
  assign cur_sel  = sel;

  // Ready is gated by reset so no upstream beat is consumed while it is asserted.
  always_comb begin
    in_ready  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        in_ready[i] = can_take && !reset;
        sel_valid   = in_valid[i];
      end
    end
  end

  assign acc = sel_valid && can_take;

  always_ff @(posedge clock) begin
    if (reset) begin
      sel       <= '0;
      cfg_err   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (cfg_we) begin
        if (cfg_ok) sel     <= cfg_sel;
        else        cfg_err <= 1'b1;
      end
      if (acc) begin
        out_data  <= mux_data;
        out_valid <= 1'b1;
        if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed self-checking bench for stream_mux_nto1 (default build plus a CNT_W=4 build).
module tb_stream_mux_nto1;

  localparam int WIDTH = 32;
  localparam int N_IN  = 5;
  localparam int SEL_W = 3;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  cfg_we;
  logic [SEL_W-1:0]      cfg_sel;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic                  out_ready;

  logic                  cfg_err,   cfg_err_s;
  logic [SEL_W-1:0]      cur_sel,   cur_sel_s;
  logic [N_IN-1:0]       in_ready,  in_ready_s;
  logic [WIDTH-1:0]      out_data,  out_data_s;
  logic                  out_valid, out_valid_s;
  logic [15:0]           xfer_cnt;
  logic [3:0]            xfer_cnt_s;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stream_mux_nto1 #(.WIDTH(WIDTH), .N_IN(N_IN), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_err(cfg_err), .cur_sel(cur_sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  stream_mux_nto1 #(.WIDTH(WIDTH), .N_IN(N_IN), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_err(cfg_err_s), .cur_sel(cur_sel_s), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .xfer_cnt(xfer_cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; out_ready = 1'b1;
    in_valid = '1;
    for (int i = 0; i < N_IN; i++) set_ch(i, 32'hC00 + i);

    // Reset, two cycles, with every input offering a beat
    tick();
    chk("rst_ready_1", in_ready, 5'b00000);
    tick();
    chk("rst_ready_2", in_ready, 5'b00000);
    chk("rst_ready_sat", in_ready_s, 5'b00000);
    reset = 1'b0;
    in_valid = '0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_cur_sel", cur_sel, 3'd0);
    chk("rst_xfer_cnt", xfer_cnt, 16'd0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("idle_ready_ch0", in_ready, 5'b00001);

    // Streaming from channel 3
    cfg_we = 1'b1; cfg_sel = 3'd3;
    tick();
    cfg_we = 1'b0;
    chk("cfg_sel3", cur_sel, 3'd3);
    in_valid = 5'b01000;
    for (int k = 0; k < 16; k++) begin
      set_ch(3, 32'h100 + k);
      #1;
      chk("stream_ready", in_ready, 5'b01000);
      tick();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_data, 32'h100 + k);
    end
    in_valid = '0;
    #1;
    chk("stream_cnt", xfer_cnt, 16'd16);
    chk("sat_cnt_16", xfer_cnt_s, 4'd15);
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_data_hold", out_data, 32'h10F);

    // Backpressure for 4 cycles mid-stream
    in_valid = 5'b01000; set_ch(3, 32'h200);
    tick();
    chk("bp_first", out_data, 32'h200);
    out_ready = 1'b0; set_ch(3, 32'h201);
    #1;
    chk("bp_ready_low", in_ready, 5'b00000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_data", out_data, 32'h200);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_ready", in_ready, 5'b00000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 5'b01000);
    tick();
    chk("bp_after_1", out_data, 32'h201);
    set_ch(3, 32'h202);
    tick();
    chk("bp_after_2", out_data, 32'h202);
    chk("bp_cnt", xfer_cnt, 16'd19);
    chk("sat_cnt_hold", xfer_cnt_s, 4'd15);

    // Reconfigure to channel 1 on the same cycle as an accept from channel 3
    set_ch(3, 32'h300); set_ch(1, 32'h111);
    in_valid = 5'b01010;
    cfg_we = 1'b1; cfg_sel = 3'd1;
    #1;
    chk("rcfg_ready_old", in_ready, 5'b01000);
    tick();
    cfg_we = 1'b0;
    chk("rcfg_beat_old", out_data, 32'h300);
    chk("rcfg_cur_sel", cur_sel, 3'd1);
    chk("rcfg_ready_new", in_ready, 5'b00010);
    tick();
    chk("rcfg_beat_new", out_data, 32'h111);
    chk("rcfg_cnt", xfer_cnt, 16'd21);
    in_valid = '0;
    tick();
    chk("rcfg_drain", out_valid, 1'b0);

    // Illegal selects
    cfg_we = 1'b1; cfg_sel = 3'd6;
    tick();
    cfg_we = 1'b0;
    chk("ill_err", cfg_err, 1'b1);
    chk("ill_sel_kept", cur_sel, 3'd1);
    tick();
    chk("ill_err_sticky", cfg_err, 1'b1);
    cfg_we = 1'b1; cfg_sel = 3'd5;
    tick();
    chk("ill5_sel_kept", cur_sel, 3'd1);
    cfg_sel = 3'd2;
    tick();
    cfg_we = 1'b0;
    chk("legal_after_err", cur_sel, 3'd2);
    chk("err_still_set", cfg_err, 1'b1);

    // Reset mid-stream from channel 2
    in_valid = 5'b00100; set_ch(2, 32'h400);
    tick();
    chk("mid_beat", out_data, 32'h400);
    chk("mid_cnt", xfer_cnt, 16'd22);
    set_ch(2, 32'h401);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 5'b00000);
    tick();
    reset = 1'b0;
    in_valid = '0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_cnt", xfer_cnt, 16'd0);
    chk("mid_rst_sat_cnt", xfer_cnt_s, 4'd0);
    chk("mid_rst_err", cfg_err, 1'b0);
    chk("mid_rst_sel", cur_sel, 3'd0);

    // Counting restarts from zero after reset
    in_valid = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 32'h500 + k);
      tick();
      chk("post_data", out_data, 32'h500 + k);
    end
    in_valid = '0;
    chk("post_cnt", xfer_cnt, 16'd3);
    chk("post_sat_cnt", xfer_cnt_s, 4'd3);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
